// File: rtl/periph_gpio_timer.sv
// LED / debounced-button / compare-timer peripheral; reads return one cycle after the command, no wait states.
// Define PERIPH_TIMER_EN to build the timer (offsets 0x03-0x05); otherwise those offsets read 0 and timer_irq is 0.
module periph_gpio_timer #(
  parameter int   NUM_LEDS        = 3,
  parameter int   NUM_BUTTONS     = 1,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   TIMER_WIDTH     = 32,
  parameter logic SIM_FLAG        = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sel,
  input  logic                   wr,
  input  logic [5:0]             addr,
  input  logic [31:0]            wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rdata,
  output logic [NUM_LEDS-1:0]    led_n,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic                   timer_irq
);

  logic                   w_wr;
  logic                   w_wr_led;
  logic                   w_wr_evt;
  logic [31:0]            w_rd_data;
  logic [31:0]            w_timer_rd;
  logic [NUM_BUTTONS-1:0] w_stable;
  logic                   w_unused;

  logic [NUM_LEDS-1:0]    r_led;
  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] r_stable_d;
  logic [NUM_BUTTONS-1:0] r_btn_evt;
  logic                   r_rsp_valid;
  logic [31:0]            r_rdata;

  assign w_wr     = sel & wr;
  assign w_wr_led = w_wr && (addr == 6'h00);
  assign w_wr_evt = w_wr && (addr == 6'h02);

  assign led_n     = ~r_led;
  assign rsp_valid = r_rsp_valid;
  assign rdata     = r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led <= wdata[NUM_LEDS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_db_bypass
      assign w_stable = r_sync2;
    end else begin : g_db
      localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

      logic [NUM_BUTTONS-1:0] r_stable;
      logic [DB_W-1:0]        r_db_cnt [NUM_BUTTONS];

      // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_stable <= '0;
          for (int i = 0; i < NUM_BUTTONS; i++) begin
            r_db_cnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
              if (r_db_cnt[i] == DB_MAX) begin
                r_stable[i] <= r_sync2[i];
                r_db_cnt[i] <= '0;
              end else begin
                r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
              end
            end else begin
              r_db_cnt[i] <= '0;
            end
          end
        end
      end

      assign w_stable = r_stable;
    end
  endgenerate

  // A new press wins over a same-cycle W1C so no press is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= '0;
      r_btn_evt  <= '0;
    end else begin
      r_stable_d <= w_stable;
      r_btn_evt  <= (r_btn_evt & ~(w_wr_evt ? wdata[NUM_BUTTONS-1:0] : '0))
                  | (w_stable & ~r_stable_d);
    end
  end

`ifdef PERIPH_TIMER_EN
  logic                   w_wr_cnt;
  logic                   w_wr_cmp;
  logic                   w_wr_ctrl;
  logic                   w_match;
  logic                   w_cnt_run;
  logic                   w_pending_nxt;
  logic                   w_irq_en_nxt;

  logic [TIMER_WIDTH-1:0] r_count;
  logic [TIMER_WIDTH-1:0] r_cmp;
  logic                   r_en;
  logic                   r_irq_en;
  logic                   r_auto_clr;
  logic                   r_pending;
  logic                   r_irq;

  assign w_wr_cnt  = w_wr && (addr == 6'h03);
  assign w_wr_cmp  = w_wr && (addr == 6'h04);
  assign w_wr_ctrl = w_wr && (addr == 6'h05);

  // Match uses the pre-write count; a write clearing EN also suppresses this cycle's increment.
  assign w_match       = r_en && (r_count == r_cmp);
  assign w_cnt_run     = r_en & ~(w_wr_ctrl & ~wdata[0]);
  assign w_pending_nxt = (r_pending & ~(w_wr_ctrl & wdata[8])) | w_match;
  assign w_irq_en_nxt  = w_wr_ctrl ? wdata[1] : r_irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_cmp      <= '0;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_auto_clr <= 1'b0;
      r_pending  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_cnt) begin
        r_count <= wdata[TIMER_WIDTH-1:0];
      end else if (w_cnt_run) begin
        r_count <= (w_match && r_auto_clr) ? '0 : r_count + TIMER_WIDTH'(1);
      end
      if (w_wr_cmp) begin
        r_cmp <= wdata[TIMER_WIDTH-1:0];
      end
      if (w_wr_ctrl) begin
        r_en       <= wdata[0];
        r_irq_en   <= wdata[1];
        r_auto_clr <= wdata[2];
      end
      r_pending <= w_pending_nxt;
      r_irq     <= w_pending_nxt & w_irq_en_nxt;
    end
  end

  always_comb begin
    w_timer_rd = '0;
    case (addr)
      6'h03:   w_timer_rd = 32'(r_count);
      6'h04:   w_timer_rd = 32'(r_cmp);
      6'h05:   w_timer_rd = {23'b0, r_pending, 5'b0, r_auto_clr, r_irq_en, r_en};
      default: w_timer_rd = '0;
    endcase
  end

  assign timer_irq = r_irq;
`else
  assign w_timer_rd = '0;
  assign timer_irq  = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (addr)
      6'h00: w_rd_data[NUM_LEDS-1:0] = r_led;
      6'h01: begin
        w_rd_data[NUM_BUTTONS-1:0] = w_stable;
        w_rd_data[31]              = SIM_FLAG;
      end
      6'h02: w_rd_data[NUM_BUTTONS-1:0] = r_btn_evt;
      6'h03, 6'h04, 6'h05: w_rd_data = w_timer_rd;
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= sel & ~wr;
      if (sel && !wr) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign w_unused = ^{wdata, TIMER_WIDTH[0]};

endmodule

// File: tb/tb_periph_gpio_timer.sv
// Directed bench for periph_gpio_timer: 3 LEDs, 1 button, 4-cycle debounce, 8-bit timer, SIM_FLAG = 1.
module tb_periph_gpio_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        wr;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic [2:0]  led_n;
  logic [0:0]  button;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  periph_gpio_timer #(
    .NUM_LEDS(3), .NUM_BUTTONS(1), .DEBOUNCE_CYCLES(4), .TIMER_WIDTH(8), .SIM_FLAG(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .led_n(led_n), .button(button), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // All tasks start and end on a falling edge; one command occupies one cycle.
  task automatic wr_cmd(input logic [5:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_cmd(input logic [5:0] a, output logic [31:0] d, output logic v);
    sel = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    v = rsp_valid;
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        v;
    reset = 1'b1; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0; button = '0;
    idle(2);
    reset = 1'b0;
    total++; if (led_n !== 3'b111) begin bad++; $display("FAIL reset_led_n got=%b exp=111", led_n); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    rd_cmd(6'h00, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL reset_read v=%b d=%h exp v=1 d=0", v, d); end
    idle(1);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_pulse_width got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_led;
    logic [31:0] d;
    logic        v;
    wr_cmd(6'h00, 32'h5);
    total++; if (led_n !== 3'b010) begin bad++; $display("FAIL led_n_5 got=%b exp=010", led_n); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_after_write got=%b exp=0", rsp_valid); end
    rd_cmd(6'h00, d, v);
    total++; if (v !== 1'b1 || d !== 32'h5) begin bad++; $display("FAIL led_read v=%b d=%h exp v=1 d=5", v, d); end
    wr_cmd(6'h00, 32'hFFFF_FFFF);
    rd_cmd(6'h00, d, v);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL led_unimpl_bits got=%h exp=7", d); end
    total++; if (led_n !== 3'b000) begin bad++; $display("FAIL led_n_all got=%b exp=000", led_n); end
    wr_cmd(6'h3F, 32'h0);
    rd_cmd(6'h3F, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL unmapped_read v=%b d=%h exp v=1 d=0", v, d); end
    total++; if (led_n !== 3'b000) begin bad++; $display("FAIL unmapped_write_led got=%b exp=000", led_n); end
    wr_cmd(6'h00, 32'h0);
  endtask

  task automatic test_button;
    logic [31:0] d;
    logic        v;
    button = 1'b1;
    idle(3);
    button = 1'b0;
    idle(10);
    rd_cmd(6'h01, d, v);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL glitch_status got=%h exp=80000000", d); end
    rd_cmd(6'h02, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_event got=%h exp=0", d); end
    // Press at cycle 0: 2 sync edges + 4 debounce edges, level visible in cycle 6.
    button = 1'b1;
    idle(5);
    rd_cmd(6'h01, d, v);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL press_early_status got=%h exp=80000000", d); end
    rd_cmd(6'h01, d, v);
    total++; if (d !== 32'h8000_0001) begin bad++; $display("FAIL press_status got=%h exp=80000001", d); end
    rd_cmd(6'h02, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL press_event got=%h exp=1", d); end
    wr_cmd(6'h02, 32'h1);
    rd_cmd(6'h02, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL event_w1c got=%h exp=0", d); end
    button = 1'b0;
    idle(10);
    rd_cmd(6'h01, d, v);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL release_status got=%h exp=80000000", d); end
    rd_cmd(6'h02, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL release_no_event got=%h exp=0", d); end
    // Second press: W1C lands in the same cycle the event sets.
    button = 1'b1;
    idle(6);
    wr_cmd(6'h02, 32'h1);
    rd_cmd(6'h02, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL event_set_beats_clear got=%h exp=1", d); end
    wr_cmd(6'h02, 32'h1);
    rd_cmd(6'h02, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL event_w1c_again got=%h exp=0", d); end
  endtask

`ifdef PERIPH_TIMER_EN
  task automatic test_timer;
    logic [31:0] d;
    logic        v;
    wr_cmd(6'h04, 32'h5);
    wr_cmd(6'h05, 32'h7);
    // Cycle k after enabling holds count k mod 6; irq visible from cycle 6.
    for (int k = 0; k < 8; k++) begin
      rd_cmd(6'h03, d, v);
      total++; if (v !== 1'b1 || d !== 32'(k % 6)) begin bad++; $display("FAIL timer_count[%0d] v=%b got=%h exp=%h", k, v, d, k % 6); end
      total++; if (timer_irq !== (k + 1 >= 6)) begin bad++; $display("FAIL timer_irq[%0d] got=%b exp=%b", k, timer_irq, (k + 1 >= 6)); end
    end
    wr_cmd(6'h05, 32'h107);
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL irq_after_w1c got=%b exp=0", timer_irq); end
    rd_cmd(6'h05, d, v);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL ctrl_after_w1c got=%h exp=7", d); end
    idle(1);
    wr_cmd(6'h05, 32'h107);
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL irq_match_beats_w1c got=%b exp=1", timer_irq); end
    rd_cmd(6'h05, d, v);
    total++; if (d !== 32'h107) begin bad++; $display("FAIL pending_match_beats_w1c got=%h exp=107", d); end
    wr_cmd(6'h05, 32'h100);
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL irq_disable got=%b exp=0", timer_irq); end
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL count_stopped_a got=%h exp=1", d); end
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL count_stopped_b got=%h exp=1", d); end
    wr_cmd(6'h04, 32'h10);
    wr_cmd(6'h03, 32'hFE);
    wr_cmd(6'h05, 32'h1);
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'hFE) begin bad++; $display("FAIL wrap_fe got=%h exp=fe", d); end
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'hFF) begin bad++; $display("FAIL wrap_ff got=%h exp=ff", d); end
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'h00) begin bad++; $display("FAIL wrap_00 got=%h exp=0", d); end
    rd_cmd(6'h05, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL wrap_no_pending got=%h exp=1", d); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL wrap_no_irq got=%b exp=0", timer_irq); end
    wr_cmd(6'h03, 32'h40);
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'h40) begin bad++; $display("FAIL count_write_wins got=%h exp=40", d); end
    wr_cmd(6'h05, 32'h0);
  endtask
`else
  task automatic test_no_timer;
    logic [31:0] d;
    logic        v;
    wr_cmd(6'h04, 32'h1234);
    wr_cmd(6'h05, 32'h7);
    rd_cmd(6'h04, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL notimer_cmp v=%b got=%h exp=0", v, d); end
    rd_cmd(6'h05, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL notimer_ctrl got=%h exp=0", d); end
    idle(10);
    rd_cmd(6'h03, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL notimer_count got=%h exp=0", d); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL notimer_irq got=%b exp=0", timer_irq); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        v;
    wr_cmd(6'h00, 32'h5);
    sel = 1'b1; wr = 1'b0; addr = 6'h00;
    #2 reset = 1'b1;
    #1;
    total++; if (led_n !== 3'b111) begin bad++; $display("FAIL midreset_led_n got=%b exp=111", led_n); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midreset_rdata got=%h exp=0", rdata); end
    @(negedge clk);
    sel = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_read_dropped got=%b exp=0", rsp_valid); end
    reset = 1'b0;
    idle(1);
    rd_cmd(6'h00, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL midreset_led_reg v=%b got=%h exp=0", v, d); end
  endtask

  initial begin
    test_reset;
    test_led;
    test_button;
`ifdef PERIPH_TIMER_EN
    test_timer;
`else
    test_no_timer;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
